// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencing controller.
// Holds the state enum, opcode constants, mux-select encodings and the control bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EXEC = 4'd10,
        S_IMM_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_ORI = 6'b001101;

    localparam logic [1:0] ASB_REG    = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_R)   || (op == OP_LW)  || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J)   ||
               (op == OP_LUI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath bundle: decoded instruction fields and memory handshake in,
// mux selects, enables and debug observability out.
interface multi_cycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic             zero_ext;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, zero_ext,
               alu_op, pc_source, illegal_op, state, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, zero_ext,
               alu_op, pc_source, illegal_op, state, retired
    );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational control decode: state (plus opcode and mem_ready where needed)
// to every datapath select and enable.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ASB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCS_ALU;
                // IR and PC only load once memory actually returns the word
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = ASB_IMM_SH;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = !is_legal(opcode);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ASB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
            end
            S_IMM_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ASB_IMM;
                ctrl.alu_op    = ALU_IMM;
                ctrl.zero_ext  = (opcode == OP_ORI);
            end
            S_IMM_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS sequencer: next-state logic, state register and the
// retired-instruction counter; output decode lives in mc_output_decode.
module multi_cycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_cycle_control_if.master bus
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] retired_reg;
    logic             retire;
    ctrl_t            ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = S_FETCH;
        retire     = 1'b0;
        case (state_reg)
            S_FETCH:  state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:           state_next = S_R_EXEC;
                    OP_LW, OP_SW:   state_next = S_MEM_ADDR;
                    OP_BEQ:         state_next = S_BRANCH;
                    OP_J:           state_next = S_JUMP;
                    OP_LUI, OP_ORI: state_next = S_IMM_EXEC;
                    default:        state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_next = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: begin
                state_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
                retire     = bus.mem_ready;
            end
            S_R_EXEC:   state_next = S_R_WB;
            S_IMM_EXEC: state_next = S_IMM_WB;
            // Every last-step state returns to FETCH and completes an instruction
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            default:    state_next = S_FETCH;
        endcase
    end

    mc_output_decode u_output_decode (
        .state     (state_reg),
        .opcode    (bus.opcode),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.zero_ext      = ctrl.zero_ext;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.state         = state_reg;
    assign bus.retired       = retired_reg;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: walks each instruction class cycle by
// cycle and checks state, every control output and the retired count.
module tb_multi_cycle_control;

    localparam int CNT_W = 32;

    // Control vector field order:
    // pw pwc iod mr mw irw rd m2r rw asa asb[2] zx aop[2] psrc[2] ill
    localparam logic [18:0] C_FETCH_RDY  = 19'b1_0_0_1_0_1_0_0_0_0_01_0_00_00_0;
    localparam logic [18:0] C_FETCH_WAIT = 19'b0_0_0_1_0_0_0_0_0_0_01_0_00_00_0;
    localparam logic [18:0] C_DECODE     = 19'b0_0_0_0_0_0_0_0_0_0_11_0_00_00_0;
    localparam logic [18:0] C_DECODE_ILL = 19'b0_0_0_0_0_0_0_0_0_0_11_0_00_00_1;
    localparam logic [18:0] C_MEM_ADDR   = 19'b0_0_0_0_0_0_0_0_0_1_10_0_00_00_0;
    localparam logic [18:0] C_MEM_RD     = 19'b0_0_1_1_0_0_0_0_0_0_00_0_00_00_0;
    localparam logic [18:0] C_MEM_WB     = 19'b0_0_0_0_0_0_0_1_1_0_00_0_00_00_0;
    localparam logic [18:0] C_MEM_WR     = 19'b0_0_1_0_1_0_0_0_0_0_00_0_00_00_0;
    localparam logic [18:0] C_R_EXEC     = 19'b0_0_0_0_0_0_0_0_0_1_00_0_10_00_0;
    localparam logic [18:0] C_R_WB       = 19'b0_0_0_0_0_0_1_0_1_0_00_0_00_00_0;
    localparam logic [18:0] C_BRANCH     = 19'b0_1_0_0_0_0_0_0_0_1_00_0_01_01_0;
    localparam logic [18:0] C_JUMP       = 19'b1_0_0_0_0_0_0_0_0_0_00_0_00_10_0;
    localparam logic [18:0] C_ORI_EXEC   = 19'b0_0_0_0_0_0_0_0_0_1_10_1_11_00_0;
    localparam logic [18:0] C_LUI_EXEC   = 19'b0_0_0_0_0_0_0_0_0_1_10_0_11_00_0;
    localparam logic [18:0] C_IMM_WB     = 19'b0_0_0_0_0_0_0_0_1_0_00_0_00_00_0;

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] LUI = 6'b001111;
    localparam logic [5:0] ORI = 6'b001101;
    localparam logic [5:0] BAD = 6'b111111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    multi_cycle_control_if #(.CNT_W(CNT_W)) bus ();

    multi_cycle_control #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [18:0] ctl_obs;
    assign ctl_obs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                      bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.zero_ext,
                      bus.alu_op, bus.pc_source, bus.illegal_op};

    // One clock cycle: drive inputs after the falling edge, check outputs 1 ns later.
    task automatic cycle(input string tag, input logic [5:0] op, input logic rdy,
                         input logic rst_in, input logic zero_in,
                         input logic [3:0] exp_state, input logic [18:0] exp_ctl,
                         input logic [CNT_W-1:0] exp_ret);
        @(negedge clk);
        rst           = rst_in;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        bus.zero      = zero_in;
        #1;
        checks++;
        assert (bus.state === exp_state) else begin
            errors++;
            $error("FAIL %s state: got %0d expected %0d", tag, bus.state, exp_state);
        end
        checks++;
        assert (ctl_obs === exp_ctl) else begin
            errors++;
            $error("FAIL %s ctrl: got %b expected %b", tag, ctl_obs, exp_ctl);
        end
        checks++;
        assert (bus.retired === exp_ret) else begin
            errors++;
            $error("FAIL %s retired: got %0d expected %0d", tag, bus.retired, exp_ret);
        end
        $display("step %-14s op=%b rdy=%b rst=%b state=%0d ctrl=%b retired=%0d",
                 tag, op, rdy, rst_in, bus.state, ctl_obs, bus.retired);
    endtask

    initial begin
        bus.opcode    = R;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        repeat (2) @(posedge clk);

        // Reset values and R-type: 0 -> 1 -> 6 -> 7 -> 0
        cycle("r_fetch",   R,   1, 0, 0, 4'd0,  C_FETCH_RDY, 0);
        cycle("r_decode",  R,   1, 0, 0, 4'd1,  C_DECODE,    0);
        cycle("r_exec",    R,   1, 0, 0, 4'd6,  C_R_EXEC,    0);
        cycle("r_wb",      R,   1, 0, 0, 4'd7,  C_R_WB,      0);

        // lw with two wait cycles in MEM_RD: 7 cycles total
        cycle("lw_fetch",  LW,  1, 0, 0, 4'd0,  C_FETCH_RDY, 1);
        cycle("lw_decode", LW,  1, 0, 0, 4'd1,  C_DECODE,    1);
        cycle("lw_addr",   LW,  1, 0, 0, 4'd2,  C_MEM_ADDR,  1);
        cycle("lw_rd_w1",  LW,  0, 0, 0, 4'd3,  C_MEM_RD,    1);
        cycle("lw_rd_w2",  LW,  0, 0, 0, 4'd3,  C_MEM_RD,    1);
        cycle("lw_rd",     LW,  1, 0, 0, 4'd3,  C_MEM_RD,    1);
        cycle("lw_wb",     LW,  1, 0, 0, 4'd4,  C_MEM_WB,    1);

        // sw, no wait
        cycle("sw_fetch",  SW,  1, 0, 0, 4'd0,  C_FETCH_RDY, 2);
        cycle("sw_decode", SW,  1, 0, 0, 4'd1,  C_DECODE,    2);
        cycle("sw_addr",   SW,  1, 0, 0, 4'd2,  C_MEM_ADDR,  2);
        cycle("sw_wr",     SW,  1, 0, 0, 4'd5,  C_MEM_WR,    2);

        // beq with zero low, then j
        cycle("beq_fetch", BEQ, 1, 0, 0, 4'd0,  C_FETCH_RDY, 3);
        cycle("beq_dec",   BEQ, 1, 0, 0, 4'd1,  C_DECODE,    3);
        cycle("beq_br",    BEQ, 1, 0, 0, 4'd8,  C_BRANCH,    3);
        cycle("j_fetch",   J,   1, 0, 1, 4'd0,  C_FETCH_RDY, 4);
        cycle("j_decode",  J,   1, 0, 1, 4'd1,  C_DECODE,    4);
        cycle("j_jump",    J,   1, 0, 1, 4'd9,  C_JUMP,      4);

        // ori with mem_ready low outside FETCH/MEM states: must be ignored
        cycle("ori_fetch", ORI, 1, 0, 0, 4'd0,  C_FETCH_RDY, 5);
        cycle("ori_dec",   ORI, 0, 0, 0, 4'd1,  C_DECODE,    5);
        cycle("ori_exec",  ORI, 0, 0, 0, 4'd10, C_ORI_EXEC,  5);
        cycle("ori_wb",    ORI, 0, 0, 0, 4'd11, C_IMM_WB,    5);
        cycle("lui_fetch", LUI, 1, 0, 0, 4'd0,  C_FETCH_RDY, 6);
        cycle("lui_dec",   LUI, 1, 0, 0, 4'd1,  C_DECODE,    6);
        cycle("lui_exec",  LUI, 1, 0, 0, 4'd10, C_LUI_EXEC,  6);
        cycle("lui_wb",    LUI, 1, 0, 0, 4'd11, C_IMM_WB,    6);

        // Illegal opcode: one-cycle pulse, back to FETCH, count unchanged
        cycle("bad_fetch", BAD, 1, 0, 0, 4'd0,  C_FETCH_RDY, 7);
        cycle("bad_dec",   BAD, 1, 0, 0, 4'd1,  C_DECODE_ILL,7);

        // Fetch waits, then sw stalled in MEM_WR and aborted by reset
        cycle("wait_f1",   SW,  0, 0, 0, 4'd0,  C_FETCH_WAIT,7);
        cycle("wait_f2",   SW,  0, 0, 0, 4'd0,  C_FETCH_WAIT,7);
        cycle("sw2_fetch", SW,  1, 0, 0, 4'd0,  C_FETCH_RDY, 7);
        cycle("sw2_dec",   SW,  1, 0, 0, 4'd1,  C_DECODE,    7);
        cycle("sw2_addr",  SW,  1, 0, 0, 4'd2,  C_MEM_ADDR,  7);
        cycle("sw2_wr_w",  SW,  0, 0, 0, 4'd5,  C_MEM_WR,    7);
        cycle("sw2_wr_rst",SW,  0, 1, 0, 4'd5,  C_MEM_WR,    7);
        cycle("post_rst",  SW,  0, 0, 0, 4'd0,  C_FETCH_WAIT,0);
        cycle("post_rst2", R,   1, 0, 0, 4'd0,  C_FETCH_RDY, 0);
        cycle("post_dec",  R,   1, 0, 0, 4'd1,  C_DECODE,    0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
